m1_trace_buffer: RTL and testbench
==================================

M1_TRACE_BUFFER -- requirements
Module: m1_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16: trace FIFO depth in entries; power of two, at least 2.
REQ-002 Parameter STEP_LIMIT, default 100: number of M1 events after which capture stops.
REQ-003 Port clk, input, 1 bit: single system clock; the CPU clock domain (sys_clk at top level).
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port arm, input, 1 bit: level; capture is permitted while high.
REQ-006 Port m1, input, 1 bit: one-cycle pulse asserted when the CPU is in mcycle 0, tstate 0 (opcode fetch start).
REQ-007 Port pc, input, 16 bits: CPU address register, valid in the cycle m1 is high.
REQ-008 Port a, input, 8 bits: accumulator, valid in the cycle m1 is high.
REQ-009 Port f, input, 8 bits: flags register, valid in the cycle m1 is high.
REQ-010 Port out_data, output, 32 bits: head entry {pc, a, f}, with pc in the MSBs.
REQ-011 Port out_valid, output, 1 bit: the FIFO is non-empty.
REQ-012 Port out_ready, input, 1 bit: consumer accepts the entry; a pop occurs when out_valid and out_ready are both high.
REQ-013 Port done, output, 1 bit: the step limit has been reached.
REQ-014 Port drops, output, 8 bits: saturating count of entries lost to a full FIFO.

Function
REQ-015 The block SHALL run the FSM states IDLE, SKIP, CAPTURE and DONE.
REQ-016 IDLE -> SKIP when arm=1; no entry is written in IDLE.
REQ-017 SKIP -> CAPTURE on the first m1 pulse; that fetch SHALL NOT be recorded, but it SHALL increment step.
REQ-018 In CAPTURE, each m1 pulse SHALL increment step and push {pc,a,f} sampled in that same cycle.
REQ-019 The pushed entry SHALL be visible on out_data/out_valid in the cycle after the push (1-cycle latency) when the FIFO was empty.
REQ-020 Step is a 16-bit counter; on the m1 pulse at which step becomes STEP_LIMIT+1, that entry SHALL still be pushed and the FSM SHALL go to DONE.
REQ-021 In DONE, m1 pulses SHALL be ignored and done=1; the FIFO SHALL still drain normally.
REQ-022 If arm deasserts in SKIP or CAPTURE, the FSM SHALL go to IDLE, step SHALL clear, and the FIFO contents SHALL be kept.
REQ-023 Push into a full FIFO without a simultaneous pop: the entry SHALL be dropped and drops SHALL increment, saturating at 255.
REQ-024 Simultaneous push and pop when full: both SHALL succeed, occupancy is unchanged, and drops is not incremented.
REQ-025 Simultaneous push and pop when empty: the push SHALL succeed and out_valid=1 next cycle; no read-through of the incoming entry in the same cycle.
REQ-026 Read and write pointers are log2(DEPTH)+1 bits; full is indicated by equal index bits with differing MSB, and pointers SHALL wrap naturally.
REQ-027 out_data SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-028 On rst=1 at a clk edge, the block SHALL set state=IDLE, step=0, both pointers=0, drops=0, out_valid=0, done=0 and out_data=0.
REQ-029 Reset mid-capture SHALL discard all FIFO contents; m1 pulses while rst=1 SHALL be ignored.

Structure
REQ-030 A shared package trace_pkg SHALL hold the FSM state enum, the TRACE_W=32 constant and the entry field offsets.
REQ-031 The storage SHALL be a separate sub-module, trace_fifo (synchronous write, registered read head), instantiated once.
REQ-032 The FSM, step counter and drop counter SHALL reside in m1_trace_buffer.

Verification
REQ-033 Reset and arm, then pulse m1 three times with pc=0000, 0001 and 0003 -> out_data pops 0001xxxx then 0003xxxx; the first fetch is absent.
REQ-034 STEP_LIMIT=4 with 10 m1 pulses and out_ready=1 -> exactly 4 entries are popped, done=1 after the 5th pulse, and the later pulses are ignored.
REQ-035 DEPTH=4, out_ready=0, 7 captured pulses -> out_valid=1, 4 entries are held (the first four captured), and drops=3.
REQ-036 Full FIFO with a push and pop in the same cycle -> occupancy stays 4, drops is unchanged, and the order is preserved.
REQ-037 Assert rst mid-capture with 2 entries queued -> the next cycle shows out_valid=0, state=IDLE, drops=0 and done=0.
REQ-038 Pointer wrap: with out_ready=1, push 3*DEPTH entries -> all are popped in order, with no loss and no duplication.

Source files
------------

// File: rtl/trace_pkg.sv
// ============================================================================
//  Module      : trace_pkg
//  Description : Shared types and constants for the M1 opcode-fetch tracer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package trace_pkg;

    localparam int TRACE_W  = 32;
    localparam int c_pc_lsb = 16;
    localparam int c_a_lsb  = 8;
    localparam int c_f_lsb  = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP    = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic logic [TRACE_W-1:0] pack_entry(
        input logic [15:0] pc,
        input logic [7:0]  a,
        input logic [7:0]  f
    );
        logic [TRACE_W-1:0] e;
        e = '0;
        e[c_pc_lsb +: 16] = pc;
        e[c_a_lsb  +: 8]  = a;
        e[c_f_lsb  +: 8]  = f;
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trace_fifo.sv
// ============================================================================
//  Module      : trace_fifo
//  Description : Synchronous-write FIFO with a registered head-of-queue output.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = TRACE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             dropped
);

    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0]      r_wr_ptr, r_rd_ptr;
    logic [c_aw:0]      w_wr_next, w_rd_next;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [WIDTH-1:0]   r_head;
    logic               w_empty, w_full, w_pop, w_push;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]) &&
                       (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]);
    assign w_pop     = pop & ~w_empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_push    = push & (~w_full | w_pop);
    assign w_rd_next = r_rd_ptr + {{c_aw{1'b0}}, w_pop};
    assign w_wr_next = r_wr_ptr + {{c_aw{1'b0}}, w_push};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= wr_data;
        end
    end

    // The head register preloads the next entry; if that entry is the one
    // being written now, take it straight from wr_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_head   <= (w_push && (w_rd_next == r_wr_ptr)) ? wr_data
                                                            : r_mem[w_rd_next[c_aw-1:0]];
        end
    end

    assign rd_data = r_head;
    assign valid   = ~w_empty;
    assign dropped = push & ~w_push;

endmodule

`default_nettype wire

// File: rtl/m1_trace_buffer.sv
// ============================================================================
//  Module      : m1_trace_buffer
//  Description : Records {pc,a,f} at each M1 fetch after the first, up to a step limit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module m1_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int STEP_LIMIT = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               m1,
    input  logic [15:0]        pc,
    input  logic [7:0]         a,
    input  logic [7:0]         f,
    output logic [TRACE_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               done,
    output logic [7:0]         drops
);

    localparam logic [15:0] c_step_end = 16'(STEP_LIMIT + 1);

    state_t      r_state, w_state_next;
    logic [15:0] r_step, w_step_next, w_step_inc;
    logic [7:0]  r_drops;
    logic        w_push, w_dropped;

    assign w_step_inc = r_step + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_drops <= '0;
        end else begin
            r_state <= w_state_next;
            r_step  <= w_step_next;
            if (w_dropped && (r_drops != 8'hFF)) begin
                r_drops <= r_drops + 8'd1;
            end
        end
    end

    // Dropping arm wins over a coincident m1 pulse.
    always_comb begin
        w_state_next = r_state;
        w_step_next  = r_step;
        w_push       = 1'b0;
        case (r_state)
            IDLE: begin
                if (arm) w_state_next = SKIP;
            end
            SKIP: begin
                if (!arm) begin
                    w_state_next = IDLE;
                    w_step_next  = '0;
                end else if (m1) begin
                    w_state_next = CAPTURE;
                    w_step_next  = w_step_inc;
                end
            end
            CAPTURE: begin
                if (!arm) begin
                    w_state_next = IDLE;
                    w_step_next  = '0;
                end else if (m1) begin
                    w_step_next = w_step_inc;
                    w_push      = 1'b1;
                    if (w_step_inc == c_step_end) w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = DONE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TRACE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .pop     (out_ready),
        .wr_data (pack_entry(pc, a, f)),
        .rd_data (out_data),
        .valid   (out_valid),
        .dropped (w_dropped)
    );

    assign done  = (r_state == DONE);
    assign drops = r_drops;

endmodule

`default_nettype wire

// File: tb/tb_m1_trace_buffer.sv
// ============================================================================
//  Module      : tb_m1_trace_buffer
//  Description : Scoreboard bench for two tracer instances (step limit 4 and 100).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_m1_trace_buffer;
    import trace_pkg::*;

    localparam int c_depth = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        m1 = 1'b0;
    logic [15:0] pc = '0;
    logic [7:0]  a = '0;
    logic [7:0]  f = '0;
    logic        out_ready = 1'b0;

    logic [31:0] data_a, data_b;
    logic        valid_a, valid_b, done_a, done_b;
    logic [7:0]  drops_a, drops_b;

    always #5 clk = ~clk;

    m1_trace_buffer #(.DEPTH(c_depth), .STEP_LIMIT(4)) dut_a (
        .clk(clk), .rst(rst), .arm(arm), .m1(m1), .pc(pc), .a(a), .f(f),
        .out_data(data_a), .out_valid(valid_a), .out_ready(out_ready),
        .done(done_a), .drops(drops_a)
    );

    m1_trace_buffer #(.DEPTH(c_depth), .STEP_LIMIT(100)) dut_b (
        .clk(clk), .rst(rst), .arm(arm), .m1(m1), .pc(pc), .a(a), .f(f),
        .out_data(data_b), .out_valid(valid_b), .out_ready(out_ready),
        .done(done_b), .drops(drops_b)
    );

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected FIFO contents per instance, plus a small behavioural model
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    state_t      ms[2];
    int          mstep[2];
    int          mdrops[2];
    int          pops[2];
    int          lim[2] = '{4, 100};
    bit          pv[2];
    logic [31:0] pd[2];
    bit          pr, prst;

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    always @(negedge clk) begin
        logic        v, dn;
        logic [31:0] d, front;
        logic [7:0]  dr;
        bit          push;
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                v  = (k == 0) ? valid_a : valid_b;
                d  = (k == 0) ? data_a  : data_b;
                dn = (k == 0) ? done_a  : done_b;
                dr = (k == 0) ? drops_a : drops_b;
                chk($sformatf("out_valid[%0d]", k), {31'd0, v}, {31'd0, qsize(k) != 0});
                chk($sformatf("done[%0d]", k), {31'd0, dn}, {31'd0, ms[k] == DONE});
                chk($sformatf("drops[%0d]", k), {24'd0, dr}, 32'(mdrops[k]));
                if (pv[k] && !pr && !prst && v) chk($sformatf("stable[%0d]", k), d, pd[k]);
                pv[k] = v;
                pd[k] = d;
                if (rst) begin
                    if (k == 0) q0.delete(); else q1.delete();
                    ms[k] = IDLE; mstep[k] = 0; mdrops[k] = 0;
                end else begin
                    if (v && out_ready) begin
                        if (qsize(k) == 0) begin
                            chk($sformatf("pop_unexpected[%0d]", k), d, 32'hDEAD_BEEF);
                        end else begin
                            front = (k == 0) ? q0.pop_front() : q1.pop_front();
                            chk($sformatf("pop_data[%0d]", k), d, front);
                        end
                        pops[k]++;
                    end
                    push = 1'b0;
                    case (ms[k])
                        IDLE: if (arm) ms[k] = SKIP;
                        SKIP: if (!arm) begin ms[k] = IDLE; mstep[k] = 0; end
                              else if (m1) begin ms[k] = CAPTURE; mstep[k]++; end
                        CAPTURE: if (!arm) begin ms[k] = IDLE; mstep[k] = 0; end
                              else if (m1) begin
                                  mstep[k]++; push = 1'b1;
                                  if (mstep[k] == lim[k] + 1) ms[k] = DONE;
                              end
                        default: ;
                    endcase
                    if (push) begin
                        if (qsize(k) < c_depth) begin
                            if (k == 0) q0.push_back({pc, a, f}); else q1.push_back({pc, a, f});
                        end else if (mdrops[k] < 255) begin
                            mdrops[k]++;
                        end
                    end
                end
            end
            pr   = out_ready;
            prst = rst;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [15:0] p);
        pc = p;
        a  = 8'($urandom);
        f  = 8'($urandom);
        m1 = 1'b1;
        cyc();
        m1 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        pops[0] = 0;
        pops[1] = 0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            ms[k] = IDLE; mstep[k] = 0; mdrops[k] = 0; pops[k] = 0; pv[k] = 0; pd[k] = '0;
        end
        pr = 0; prst = 1;
        cyc();
        mon_en = 1'b1;
        cyc();
        chk("rst_out_data_a", data_a, 32'h0);
        chk("rst_out_data_b", data_b, 32'h0);
        chk("rst_state_b", 32'(dut_b.r_state), 32'(IDLE));
        rst = 1'b0;

        // First fetch after arming is skipped
        arm = 1'b1;
        cyc();
        pulse(16'h0000); cyc();
        pulse(16'h0001); cyc();
        pulse(16'h0003); cyc();
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("skip_pops_b", 32'(pops[1]), 32'd2);
        arm = 1'b0;
        cyc();

        // Step limit 4 on dut_a: four entries then DONE
        do_reset();
        out_ready = 1'b1;
        arm = 1'b1;
        cyc();
        for (int i = 0; i < 10; i++) begin
            pulse(16'(16'h0100 + i));
            cyc();
        end
        repeat (3) cyc();
        chk("limit_pops_a", 32'(pops[0]), 32'd4);
        chk("limit_done_a", {31'd0, done_a}, 32'd1);
        chk("limit_done_b", {31'd0, done_b}, 32'd0);

        // Overflow: 7 captures into depth 4
        do_reset();
        out_ready = 1'b0;
        arm = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++) pulse(16'(16'h0200 + i));
        cyc();
        chk("ovf_valid_b", {31'd0, valid_b}, 32'd1);
        chk("ovf_drops_b", {24'd0, drops_b}, 32'd3);

        // Full FIFO: push and pop together
        pops[0] = 0; pops[1] = 0;
        out_ready = 1'b1;
        pulse(16'hBEEF);
        out_ready = 1'b0;
        cyc();
        chk("full_pp_drops_b", {24'd0, drops_b}, 32'd3);
        out_ready = 1'b1;
        repeat (6) cyc();
        chk("full_pp_pops_b", 32'(pops[1]), 32'd5);
        chk("full_pp_pops_a", 32'(pops[0]), 32'd4);

        // Reset mid-capture with entries queued; m1 during reset ignored
        do_reset();
        out_ready = 1'b0;
        arm = 1'b1;
        cyc();
        pulse(16'h0300); pulse(16'h0301); pulse(16'h0302);
        cyc();
        chk("pre_rst_valid_b", {31'd0, valid_b}, 32'd1);
        rst = 1'b1;
        pulse(16'h0377);
        rst = 1'b0;
        chk("mid_rst_valid_b", {31'd0, valid_b}, 32'd0);
        chk("mid_rst_state_b", 32'(dut_b.r_state), 32'(IDLE));
        chk("mid_rst_drops_b", {24'd0, drops_b}, 32'd0);
        chk("mid_rst_done_a", {31'd0, done_a}, 32'd0);

        // Pointer wrap: 3*DEPTH back-to-back captures
        pops[0] = 0; pops[1] = 0;
        out_ready = 1'b1;
        cyc();
        pulse(16'h0400);
        for (int i = 1; i <= 3 * c_depth; i++) pulse(16'(16'h0400 + i));
        repeat (3) cyc();
        chk("wrap_pops_b", 32'(pops[1]), 32'(3 * c_depth));

        // Disarm keeps contents; rearm skips a fetch again
        do_reset();
        out_ready = 1'b0;
        arm = 1'b1;
        cyc();
        pulse(16'h0500); pulse(16'h0501); pulse(16'h0502);
        arm = 1'b0;
        cyc(); cyc();
        chk("disarm_valid_b", {31'd0, valid_b}, 32'd1);
        chk("disarm_state_b", 32'(dut_b.r_state), 32'(IDLE));
        arm = 1'b1;
        cyc();
        pulse(16'h0600); pulse(16'h0601);
        out_ready = 1'b1;
        repeat (5) cyc();
        chk("rearm_pops_b", 32'(pops[1]), 32'd3);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
